// File: rtl/port_request_queue.sv
// Three independent per-port request FIFOs in front of the banked memory cluster; heads are held while the cluster freezes.
// Enqueue-to-present latency is 1 cycle, with no bypass; a full FIFO refuses pushes even when it pops in the same cycle.

module port_request_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [11:0]   in_addr,
    input  logic [15:0]   in_data,
    input  logic          in_wen,
    output logic [1:0]    in_tag,
    input  logic          freeze,
    output logic          head_valid,
    output logic [1:0]    head_tag,
    output logic [11:0]   head_addr,
    output logic [15:0]   head_data,
    output logic          head_wen,
    output logic [AW:0]   count
);
    typedef struct packed {
        logic [1:0]  tag;
        logic [11:0] addr;
        logic [15:0] data;
        logic        wen;
    } entry_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    assign in_ready   = (count != FULL);
    assign head_valid = (count != '0);
    assign push       = in_valid & in_ready;
    // A frozen cycle never pops, so the head stays bit-identical.
    assign pop        = head_valid & ~freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            in_tag <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                in_tag <= in_tag + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: in_tag, addr: in_addr, data: in_data, wen: in_wen};
        end
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign head      = head_valid ? mem[rd_ptr] : '0;
    assign head_tag  = head.tag;
    assign head_addr = head.addr;
    assign head_data = head.data;
    assign head_wen  = head.wen;
endmodule

module port_request_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   client1_valid,
    output logic                   client1_ready,
    input  logic [11:0]            client1_addr,
    input  logic [15:0]            client1_data,
    input  logic                   client1_wen,
    output logic [1:0]             client1_tag,
    input  logic                   client2_valid,
    output logic                   client2_ready,
    input  logic [11:0]            client2_addr,
    input  logic [15:0]            client2_data,
    input  logic                   client2_wen,
    output logic [1:0]             client2_tag,
    input  logic                   client3_valid,
    output logic                   client3_ready,
    input  logic [11:0]            client3_addr,
    input  logic [15:0]            client3_data,
    input  logic                   client3_wen,
    output logic [1:0]             client3_tag,
    output logic [1:0]             port1_req_tag_in,
    output logic [11:0]            port1_addr,
    output logic [15:0]            port1_data_in,
    output logic                   port1_wen,
    output logic                   port1_valid,
    output logic [1:0]             port2_req_tag_in,
    output logic [11:0]            port2_addr,
    output logic [15:0]            port2_data_in,
    output logic                   port2_wen,
    output logic                   port2_valid,
    output logic [1:0]             port3_req_tag_in,
    output logic [11:0]            port3_addr,
    output logic [15:0]            port3_data_in,
    output logic                   port3_wen,
    output logic                   port3_valid,
    input  logic                   freeze_inputs,
    output logic [$clog2(DEPTH):0] port1_count,
    output logic [$clog2(DEPTH):0] port2_count,
    output logic [$clog2(DEPTH):0] port3_count,
    output logic [15:0]            stall_cycles
);
    port_request_queue_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset),
        .in_valid(client1_valid), .in_ready(client1_ready), .in_addr(client1_addr),
        .in_data(client1_data), .in_wen(client1_wen), .in_tag(client1_tag),
        .freeze(freeze_inputs), .head_valid(port1_valid), .head_tag(port1_req_tag_in),
        .head_addr(port1_addr), .head_data(port1_data_in), .head_wen(port1_wen),
        .count(port1_count)
    );

    port_request_queue_fifo #(.DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .reset(reset),
        .in_valid(client2_valid), .in_ready(client2_ready), .in_addr(client2_addr),
        .in_data(client2_data), .in_wen(client2_wen), .in_tag(client2_tag),
        .freeze(freeze_inputs), .head_valid(port2_valid), .head_tag(port2_req_tag_in),
        .head_addr(port2_addr), .head_data(port2_data_in), .head_wen(port2_wen),
        .count(port2_count)
    );

    port_request_queue_fifo #(.DEPTH(DEPTH)) u_fifo3 (
        .clk(clk), .reset(reset),
        .in_valid(client3_valid), .in_ready(client3_ready), .in_addr(client3_addr),
        .in_data(client3_data), .in_wen(client3_wen), .in_tag(client3_tag),
        .freeze(freeze_inputs), .head_valid(port3_valid), .head_tag(port3_req_tag_in),
        .head_addr(port3_addr), .head_data(port3_data_in), .head_wen(port3_wen),
        .count(port3_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (freeze_inputs && (port1_valid || port2_valid || port3_valid)
                     && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
endmodule

// File: tb/tb_port_request_queue.sv
// Directed table of per-cycle vectors for port_request_queue, plus hand-written wrap-around and reset-while-busy sequences.
module tb_port_request_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cv;
    logic [11:0] addr;
    logic [15:0] data;
    logic        wen;
    logic        frz;

    logic        r1, r2, r3;
    logic [1:0]  ct1, ct2, ct3;
    logic [1:0]  t1, t2, t3;
    logic [11:0] a1, a2, a3;
    logic [15:0] d1, d2, d3;
    logic        w1, w2, w3;
    logic        v1, v2, v3;
    logic [2:0]  c1, c2, c3;
    logic [15:0] stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    port_request_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .client1_valid(cv[0]), .client1_ready(r1), .client1_addr(addr),
        .client1_data(data), .client1_wen(wen), .client1_tag(ct1),
        .client2_valid(cv[1]), .client2_ready(r2), .client2_addr(addr),
        .client2_data(data), .client2_wen(wen), .client2_tag(ct2),
        .client3_valid(cv[2]), .client3_ready(r3), .client3_addr(addr),
        .client3_data(data), .client3_wen(wen), .client3_tag(ct3),
        .port1_req_tag_in(t1), .port1_addr(a1), .port1_data_in(d1), .port1_wen(w1), .port1_valid(v1),
        .port2_req_tag_in(t2), .port2_addr(a2), .port2_data_in(d2), .port2_wen(w2), .port2_valid(v2),
        .port3_req_tag_in(t3), .port3_addr(a3), .port3_data_in(d3), .port3_wen(w3), .port3_valid(v3),
        .freeze_inputs(frz),
        .port1_count(c1), .port2_count(c2), .port3_count(c3),
        .stall_cycles(stall)
    );

    typedef struct {
        bit        rst;
        bit        frz;
        bit [2:0]  cv;
        bit [11:0] addr;
        bit [15:0] data;
        bit        wen;
        bit [2:0]  pv;
        bit [5:0]  htag;   // {t3,t2,t1}
        bit [11:0] a1;
        bit [11:0] a2;
        bit [11:0] a3;
        bit [15:0] d1;
        bit [2:0]  c1;
        bit [2:0]  c2;
        bit [2:0]  c3;
        bit [2:0]  rdy;    // {r3,r2,r1}
        bit [5:0]  ctag;   // {ct3,ct2,ct1}
        bit [15:0] stall;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit f, input logic [2:0] v,
                        input logic [11:0] a, input logic [15:0] d, input logic w);
        reset = r; frz = f; cv = v; addr = a; data = d; wen = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; frz = 1'b0; cv = 3'b000; addr = '0; data = '0; wen = 1'b0;

        //        rst frz cv      addr     data      wen  pv      htag       a1       a2       a3       d1        c1 c2 c3 rdy     ctag       stall
        vt[0]  = '{1, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b000, 6'b000000, 12'h000, 12'h000, 12'h000, 16'h0000, 0, 0, 0, 3'b111, 6'b000000, 0};
        vt[1]  = '{0, 0, 3'b001, 12'h005, 16'hBEEF, 1, 3'b001, 6'b000000, 12'h005, 12'h000, 12'h000, 16'hBEEF, 1, 0, 0, 3'b111, 6'b000001, 0};
        vt[2]  = '{0, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b000, 6'b000000, 12'h000, 12'h000, 12'h000, 16'h0000, 0, 0, 0, 3'b111, 6'b000001, 0};
        vt[3]  = '{0, 1, 3'b010, 12'h010, 16'h0000, 0, 3'b010, 6'b000000, 12'h000, 12'h010, 12'h000, 16'h0000, 0, 1, 0, 3'b111, 6'b000101, 0};
        vt[4]  = '{0, 1, 3'b010, 12'h011, 16'h0000, 0, 3'b010, 6'b000000, 12'h000, 12'h010, 12'h000, 16'h0000, 0, 2, 0, 3'b111, 6'b001001, 1};
        vt[5]  = '{0, 1, 3'b000, 12'h000, 16'h0000, 0, 3'b010, 6'b000000, 12'h000, 12'h010, 12'h000, 16'h0000, 0, 2, 0, 3'b111, 6'b001001, 2};
        vt[6]  = '{0, 1, 3'b000, 12'h000, 16'h0000, 0, 3'b010, 6'b000000, 12'h000, 12'h010, 12'h000, 16'h0000, 0, 2, 0, 3'b111, 6'b001001, 3};
        vt[7]  = '{0, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b010, 6'b000100, 12'h000, 12'h011, 12'h000, 16'h0000, 0, 1, 0, 3'b111, 6'b001001, 3};
        vt[8]  = '{0, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b000, 6'b000000, 12'h000, 12'h000, 12'h000, 16'h0000, 0, 0, 0, 3'b111, 6'b001001, 3};
        vt[9]  = '{0, 1, 3'b100, 12'h020, 16'h1234, 1, 3'b100, 6'b000000, 12'h000, 12'h000, 12'h020, 16'h0000, 0, 0, 1, 3'b111, 6'b011001, 3};
        vt[10] = '{0, 1, 3'b100, 12'h021, 16'h1234, 1, 3'b100, 6'b000000, 12'h000, 12'h000, 12'h020, 16'h0000, 0, 0, 2, 3'b111, 6'b101001, 4};
        vt[11] = '{0, 1, 3'b100, 12'h022, 16'h1234, 1, 3'b100, 6'b000000, 12'h000, 12'h000, 12'h020, 16'h0000, 0, 0, 3, 3'b111, 6'b111001, 5};
        vt[12] = '{0, 1, 3'b100, 12'h023, 16'h1234, 1, 3'b100, 6'b000000, 12'h000, 12'h000, 12'h020, 16'h0000, 0, 0, 4, 3'b011, 6'b001001, 6};
        vt[13] = '{0, 1, 3'b100, 12'h024, 16'h1234, 1, 3'b100, 6'b000000, 12'h000, 12'h000, 12'h020, 16'h0000, 0, 0, 4, 3'b011, 6'b001001, 7};
        vt[14] = '{0, 0, 3'b100, 12'h025, 16'h1234, 1, 3'b100, 6'b010000, 12'h000, 12'h000, 12'h021, 16'h0000, 0, 0, 3, 3'b111, 6'b001001, 7};
        vt[15] = '{0, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b100, 6'b100000, 12'h000, 12'h000, 12'h022, 16'h0000, 0, 0, 2, 3'b111, 6'b001001, 7};
        vt[16] = '{0, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b100, 6'b110000, 12'h000, 12'h000, 12'h023, 16'h0000, 0, 0, 1, 3'b111, 6'b001001, 7};
        vt[17] = '{0, 0, 3'b000, 12'h000, 16'h0000, 0, 3'b000, 6'b000000, 12'h000, 12'h000, 12'h000, 16'h0000, 0, 0, 0, 3'b111, 6'b001001, 7};

        for (int i = 0; i < 18; i++) begin
            step(vt[i].rst, vt[i].frz, vt[i].cv, vt[i].addr, vt[i].data, vt[i].wen);
            chk($sformatf("v%0d valid", i), {29'd0, v3, v2, v1}, {29'd0, vt[i].pv});
            chk($sformatf("v%0d head_tag", i), {26'd0, t3, t2, t1}, {26'd0, vt[i].htag});
            chk($sformatf("v%0d addr1", i), {20'd0, a1}, {20'd0, vt[i].a1});
            chk($sformatf("v%0d addr2", i), {20'd0, a2}, {20'd0, vt[i].a2});
            chk($sformatf("v%0d addr3", i), {20'd0, a3}, {20'd0, vt[i].a3});
            chk($sformatf("v%0d data1", i), {16'd0, d1}, {16'd0, vt[i].d1});
            chk($sformatf("v%0d counts", i), {23'd0, c3, c2, c1}, {23'd0, vt[i].c3, vt[i].c2, vt[i].c1});
            chk($sformatf("v%0d ready", i), {29'd0, r3, r2, r1}, {29'd0, vt[i].rdy});
            chk($sformatf("v%0d client_tag", i), {26'd0, ct3, ct2, ct1}, {26'd0, vt[i].ctag});
            chk($sformatf("v%0d stall", i), {16'd0, stall}, {16'd0, vt[i].stall});
        end
        chk("v1-check wen1 after drain", {31'd0, w1}, 32'd0);

        // Wrap-around: six entries through a depth-4 FIFO, the first two built up while frozen.
        step(1'b1, 1'b0, 3'b000, 12'h000, 16'h0000, 1'b0);
        for (int c = 0; c < 8; c++) begin
            int h;
            int ec;
            step(1'b0, c < 2, (c < 6) ? 3'b001 : 3'b000, 12'(12'h100 + c), 16'(16'hA000 + c), 1'b0);
            h  = (c < 2) ? 0 : c - 1;
            ec = (c == 0) ? 1 : (c < 6) ? 2 : (c == 6) ? 1 : 0;
            chk($sformatf("wrap c%0d count1", c), {29'd0, c1}, ec);
            if (c < 7) begin
                chk($sformatf("wrap c%0d valid1", c), {31'd0, v1}, 32'd1);
                chk($sformatf("wrap c%0d tag1", c), {30'd0, t1}, h % 4);
                chk($sformatf("wrap c%0d addr1", c), {20'd0, a1}, 32'h100 + h);
                chk($sformatf("wrap c%0d data1", c), {16'd0, d1}, 32'hA000 + h);
            end else begin
                chk("wrap empty valid1", {31'd0, v1}, 32'd0);
                chk("wrap empty addr1", {20'd0, a1}, 32'd0);
            end
        end

        // Reset while frozen with entries queued and clients still pushing.
        step(1'b0, 1'b1, 3'b111, 12'h0AA, 16'h5555, 1'b1);
        chk("busy counts", {23'd0, c3, c2, c1}, {23'd0, 3'd1, 3'd1, 3'd1});
        step(1'b1, 1'b1, 3'b111, 12'h0BB, 16'h6666, 1'b1);
        chk("rst valid", {29'd0, v3, v2, v1}, 32'd0);
        chk("rst counts", {23'd0, c3, c2, c1}, 32'd0);
        chk("rst stall", {16'd0, stall}, 32'd0);
        chk("rst client_tag", {26'd0, ct3, ct2, ct1}, 32'd0);
        chk("rst ready", {29'd0, r3, r2, r1}, 32'd7);
        chk("rst heads", {a3, a2, a1}, 32'd0);
        chk("rst data", {d3[7:0], d2[7:0], d1}, 32'd0);

        step(1'b0, 1'b0, 3'b000, 12'h000, 16'h0000, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
